// File: rtl/ppa_pipe.sv
// ppa_pipe: pipelined Kogge-Stone parallel-prefix adder with valid/ready stream handshake.
// Carry-in is injected as prefix node 0, so every carry comes out of the tree directly.
//
// Parameters:
//   WIDTH       operand width (>=2); LEVELS = clog2(WIDTH) prefix levels
//   PIPE_EVERY  register after every PIPE_EVERY prefix levels; 0 = output register only
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake (in_ready is combinational)
//   a, b, cin             operands and carry-in
//   out_valid / out_ready result beat handshake
//   sum, cout             a + b + cin (low WIDTH bits) and carry out of the MSB
// Optional feature macro PPA_PIPE_SUB_EN:
//   adds input sub (a - b when set, cout=1 means no borrow) and output ovf
//   (signed overflow), both travelling with the beat.

module ppa_pipe #(
    parameter int WIDTH      = 16,
    parameter int PIPE_EVERY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PPA_PIPE_SUB_EN
    ,
    input  logic             sub,
    output logic             ovf
`endif
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int PE_DIV = (PIPE_EVERY == 0) ? 1 : PIPE_EVERY;

    // Global stall: every stage moves together, so no bubble collapse.
    logic w_adv;
    assign w_adv    = out_ready | ~out_valid;
    assign in_ready = w_adv;

    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
`ifdef PPA_PIPE_SUB_EN
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub | cin;
`else
    assign w_b_eff   = b;
    assign w_cin_eff = cin;
`endif

    logic [WIDTH-1:0] w_praw;
    logic [WIDTH-1:0] w_graw;
    assign w_praw = a ^ w_b_eff;
    assign w_graw = a & w_b_eff;

    // Boundary signals between prefix levels; index k = after k levels.
    // Node j of the tree stands for bit position j-1, node 0 being cin,
    // so the final group generate at node j is the carry into bit j.
    logic             w_v  [0:LEVELS];
    logic [WIDTH-1:0] w_g  [0:LEVELS];
    logic [WIDTH-1:0] w_p  [0:LEVELS];
    logic [WIDTH-1:0] w_pr [0:LEVELS];
    logic             w_gm [0:LEVELS];

    assign w_v[0]  = in_valid & w_adv;
    assign w_g[0]  = {w_graw[WIDTH-2:0], w_cin_eff};
    assign w_p[0]  = {w_praw[WIDTH-2:0], 1'b0};
    assign w_pr[0] = w_praw;
    assign w_gm[0] = w_graw[WIDTH-1];

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int D  = 1 << k;
        localparam int M2 = (2 * D < WIDTH) ? 2 * D : WIDTH;
        // Nodes below M2 reach node 0 after this level: grey cells, no P.
        localparam logic [WIDTH-1:0] K_HI = {WIDTH{1'b1}} << M2;

        logic [WIDTH-1:0] w_gs;
        logic [WIDTH-1:0] w_ps;
        logic [WIDTH-1:0] w_go;
        logic [WIDTH-1:0] w_po;

        assign w_gs = w_g[k] << D;
        assign w_ps = w_p[k] << D;
        assign w_go = w_g[k] | (w_p[k] & w_gs);
        assign w_po = w_p[k] & w_ps & K_HI;

        if ((PIPE_EVERY != 0) && (((k + 1) % PE_DIV) == 0)
            && (k + 1 < LEVELS)) begin : g_reg
            logic             r_v;
            logic [WIDTH-1:0] r_g;
            logic [WIDTH-1:0] r_p;
            logic [WIDTH-1:0] r_pr;
            logic             r_gm;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v  <= 1'b0;
                    r_g  <= '0;
                    r_p  <= '0;
                    r_pr <= '0;
                    r_gm <= 1'b0;
                end else if (w_adv) begin
                    r_v  <= w_v[k];
                    r_g  <= w_go;
                    r_p  <= w_po;
                    r_pr <= w_pr[k];
                    r_gm <= w_gm[k];
                end
            end

            assign w_v[k+1]  = r_v;
            assign w_g[k+1]  = r_g;
            assign w_p[k+1]  = r_p;
            assign w_pr[k+1] = r_pr;
            assign w_gm[k+1] = r_gm;
        end else begin : g_thru
            assign w_v[k+1]  = w_v[k];
            assign w_g[k+1]  = w_go;
            assign w_p[k+1]  = w_po;
            assign w_pr[k+1] = w_pr[k];
            assign w_gm[k+1] = w_gm[k];
        end
    end

    // Group propagate after the last level has no consumer.
    logic w_unused_p;
    assign w_unused_p = ^w_p[LEVELS];

    logic [WIDTH-1:0] w_c;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    assign w_c    = w_g[LEVELS];
    assign w_sum  = w_pr[LEVELS] ^ w_c;
    // The tree spans WIDTH nodes; the MSB cell closes the carry chain.
    assign w_cout = w_gm[LEVELS] | (w_pr[LEVELS][WIDTH-1] & w_c[WIDTH-1]);

    logic             r_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_adv) begin
            r_valid <= w_v[LEVELS];
            r_sum   <= w_sum;
            r_cout  <= w_cout;
        end
    end

    assign out_valid = r_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

`ifdef PPA_PIPE_SUB_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_ovf <= w_c[WIDTH-1] ^ w_cout;
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_ppa_pipe.sv
// tb_ppa_pipe: self-checking bench for ppa_pipe (WIDTH=16, PIPE_EVERY=1 and 0).
// Directed vector table, random streaming with backpressure, reset in flight.

module tb_ppa_pipe;

    localparam int W = 16;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, sum;
    logic         cin, cout;
    logic         sub;
    logic         in_valid1, in_ready1, out_valid1, out_ready1;
    logic [W-1:0] sum1;
    logic         cout1;
`ifdef PPA_PIPE_SUB_EN
    logic         ovf, ovf1;
`endif

    ppa_pipe #(.WIDTH(W), .PIPE_EVERY(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef PPA_PIPE_SUB_EN
        , .sub(sub), .ovf(ovf)
`endif
    );

    ppa_pipe #(.WIDTH(W), .PIPE_EVERY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1)
`ifdef PPA_PIPE_SUB_EN
        , .sub(sub), .ovf(ovf1)
`endif
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc_cyc;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] esum;
        logic         ecout;
        logic         eovf;
    } vec_t;

    exp_t         q[$];
    vec_t         vecs[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           nacc = 0;
    int           nret = 0;
    logic [W-1:0] ret_sum;
    logic         ret_cout;
    logic         ret_ovf;
    int           ret_lat;

    function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y,
                                   logic ci, logic s);
        exp_t    e;
        longint  ux, uy, ur;
        longint  sx, sy, sr;
        ux = longint'(x);
        uy = longint'(y);
        sx = (ux >= (64'd1 << (W - 1))) ? ux - (64'd1 << W) : ux;
        sy = (uy >= (64'd1 << (W - 1))) ? uy - (64'd1 << W) : uy;
        if (s) begin
            ur = ux - uy + (64'd1 << W);
            sr = sx - sy;
        end else begin
            ur = ux + uy + longint'(ci);
            sr = sx + sy + longint'(ci);
        end
        e.sum     = ur[W-1:0];
        e.cout    = ur[W];
        e.ovf     = (sr >= (64'sd1 <<< (W - 1))) || (sr < -(64'sd1 <<< (W - 1)));
        e.acc_cyc = 0;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge with inputs already set; models the next rising edge.
    task automatic step();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("extra_result_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("sum", {16'd0, sum}, {16'd0, e.sum});
                chk("cout", {31'd0, cout}, {31'd0, e.cout});
`ifdef PPA_PIPE_SUB_EN
                chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                ret_ovf = ovf;
`endif
                ret_sum  = sum;
                ret_cout = cout;
                ret_lat  = cyc - e.acc_cyc;
                nret++;
            end
        end
        if (in_valid && in_ready) begin
            e = model(a, b, cin, sub);
            e.acc_cyc = cyc;
            q.push_back(e);
            nacc++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int bound, output int n);
        n = 0;
        while (q.size() != 0 && n < bound) begin
            step();
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic rand_ops();
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc0;
        int ret0;
        vec_t v;
        exp_t e0;

        rst_n = 1'b0;
        in_valid = 1'b0; in_valid1 = 1'b0;
        out_ready = 1'b1; out_ready1 = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0});
        vecs.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0});
        vecs.push_back('{16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0});
        vecs.push_back('{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1});
`ifdef PPA_PIPE_SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0});
        vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1});
`endif

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_sum", {16'd0, sum}, 32'd0);
        chk("reset_cout", {31'd0, cout}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, one beat at a time, latency 4.
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            a = v.a; b = v.b; cin = v.cin; sub = v.sub;
            in_valid = 1'b1;
            ret_lat = -1;
            step();
            in_valid = 1'b0;
            drain(10, n);
            chk($sformatf("vec%0d_sum", i), {16'd0, ret_sum}, {16'd0, v.esum});
            chk($sformatf("vec%0d_cout", i), {31'd0, ret_cout}, {31'd0, v.ecout});
            chk($sformatf("vec%0d_latency", i), ret_lat, 4);
`ifdef PPA_PIPE_SUB_EN
            chk($sformatf("vec%0d_ovf", i), {31'd0, ret_ovf}, {31'd0, v.eovf});
`endif
        end
        sub = 1'b0;

        // 100 back-to-back beats: one result per clock, drains in exactly L cycles.
        acc0 = nacc;
        ret0 = nret;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rand_ops();
`ifdef PPA_PIPE_SUB_EN
            sub = 1'($urandom);
`endif
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        drain(10, n);
        chk("stream_accepts", nacc - acc0, 100);
        chk("stream_results", nret - ret0, 100);
        chk("stream_drain_cycles", n, 4);

        // Backpressure with a full pipe: held outputs, no loss or duplication.
        for (int i = 0; i < 6; i++) begin
            rand_ops();
            in_valid = 1'b1;
            step();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            in_valid = 1'b1;
            #1;
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_sum_held", {16'd0, sum}, {16'd0, q[0].sum});
            chk("stall_cout_held", {31'd0, cout}, {31'd0, q[0].cout});
            step();
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        drain(10, n);
        for (int i = 0; i < 3; i++) step();
        chk("stall_no_loss", nret, nacc);

        // Random valid/ready traffic.
        for (int i = 0; i < 300; i++) begin
            rand_ops();
`ifdef PPA_PIPE_SUB_EN
            sub = 1'($urandom);
`endif
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        sub = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain(20, n);
        chk("random_no_loss", nret, nacc);

        // PIPE_EVERY=0 instance: latency 1.
        in_valid1 = 1'b1;
        a = 16'h1234; b = 16'h4321; cin = 1'b1;
        @(negedge clk);
        #1;
        chk("l1_out_valid", {31'd0, out_valid1}, 32'd1);
        chk("l1_sum", {16'd0, sum1}, 32'h5556);
        chk("l1_cout", {31'd0, cout1}, 32'd0);
        in_valid1 = 1'b0;
        @(negedge clk);
        #1;
        chk("l1_single_beat", {31'd0, out_valid1}, 32'd0);
        @(negedge clk);

        // Reset with beats in flight in both instances.
        for (int i = 0; i < 4; i++) begin
            a = 16'h1111 + W'(i); b = 16'h2222; cin = 1'b0;
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_valid1 = 1'b1;
        a = 16'h1111; b = 16'h2222;
        step();
        in_valid1 = 1'b0;
        e0 = q[0];
        chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        chk("pre_reset_sum", {16'd0, sum}, {16'd0, e0.sum});
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_sum", {16'd0, sum}, 32'd0);
        chk("midrst_cout", {31'd0, cout}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_l1_valid", {31'd0, out_valid1}, 32'd0);
        chk("midrst_l1_sum", {16'd0, sum1}, 32'd0);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (out_valid || out_valid1) n++;
            step();
        end
        chk("post_reset_stale", n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
